// File: rtl/nibble_sequencer.sv
// Multi-cycle fetch/execute sequencer for the nibble processor: walks the program ROM,
// gates data-memory writes, inserts the overflow-correction cycle and drives memory dumps.
module nibble_sequencer #(
    parameter int PROG_LEN  = 16,
    parameter int MEM_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] instr,
    input  logic        ovf,
    output logic [3:0]  pc,
    output logic [7:0]  op,
    output logic [3:0]  x_out,
    output logic [3:0]  addr_out,
    output logic        mem_we,
    output logic        ovf_phase,
    output logic        dump_valid,
    output logic [3:0]  dump_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  instr_count
);
    localparam logic [3:0] LAST_PC   = 4'(PROG_LEN - 1);
    localparam logic [3:0] LAST_DUMP = 4'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, OVF, DUMP, HALT} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pc_q, pc_d;
    logic [10:0] ir_q, ir_d;
    logic [3:0]  dump_q, dump_d;
    logic [7:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        retire;
    logic        unused_instr_msb;

    // The top opcode bit carries no meaning for this machine.
    assign unused_instr_msb = instr[11];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            dump_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            dump_q  <= dump_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        dump_d  = '0;
        count_d = count_q;
        err_d   = err_q;
        retire  = 1'b0;

        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = '0;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            FETCH: begin
                ir_d    = instr[10:0];
                state_d = EXEC;
            end
            EXEC: begin
                case (ir_q[10:8])
                    3'b100:         state_d = HALT;
                    3'b101, 3'b110: retire = 1'b1;
                    3'b111:         state_d = DUMP;
                    default: begin
                        if (ovf) state_d = OVF;
                        else     retire = 1'b1;
                    end
                endcase
            end
            OVF: retire = 1'b1;
            DUMP: begin
                if (dump_q == LAST_DUMP) retire = 1'b1;
                else                     dump_d = dump_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase

        // Retiring the last program word stops the run with an error instead of wrapping pc.
        if (retire) begin
            count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
            if (pc_q == LAST_PC) begin
                state_d = HALT;
                err_d   = 1'b1;
            end else begin
                pc_d    = pc_q + 4'd1;
                state_d = FETCH;
            end
        end
    end

    assign pc          = pc_q;
    assign op          = (state_q == EXEC || state_q == OVF || state_q == DUMP) ? {5'b0, ir_q[10:8]} : 8'h00;
    assign x_out       = ir_q[3:0];
    assign addr_out    = ir_q[7:4];
    assign mem_we      = (state_q == EXEC && !ir_q[10]) || state_q == OVF;
    assign ovf_phase   = (state_q == OVF);
    assign dump_valid  = (state_q == DUMP);
    assign dump_addr   = dump_q;
    assign busy        = (state_q == FETCH || state_q == EXEC || state_q == OVF || state_q == DUMP);
    assign done        = (state_q == HALT);
    assign err         = err_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_nibble_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for nibble_sequencer: an instruction-level model predicts every write,
// dump beat and final status; a negedge monitor checks what the DUT presents.
module tb_nibble_sequencer;
    localparam int KIND_WRITE = 0;
    localparam int KIND_OVF   = 1;
    localparam int KIND_DUMP  = 2;
    localparam int KIND_DONE  = 3;
    localparam int DEPTH      = 16;

    typedef struct {
        int         kind;
        logic [3:0] pc;
        logic [3:0] addr;
        logic [3:0] x;
        logic [7:0] op;
        logic       err;
        logic [7:0] count;
        int         latency;
    } event_t;

    logic        clk = 1'b0;
    logic        rst_n, start, ovf;
    logic [11:0] instr;
    logic [3:0]  pc, x_out, addr_out, dump_addr;
    logic [7:0]  op, instr_count;
    logic        mem_we, ovf_phase, dump_valid, busy, done, err;

    logic [11:0] rom [16];
    logic        ovfMap [16];
    event_t      expQ [$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          startCyc = 0;
    int          doneCount = 0;
    int          doneBase = 0;
    logic        prevDone = 1'b0;

    always #5 clk = ~clk;

    nibble_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .ovf(ovf),
        .pc(pc), .op(op), .x_out(x_out), .addr_out(addr_out), .mem_we(mem_we),
        .ovf_phase(ovf_phase), .dump_valid(dump_valid), .dump_addr(dump_addr),
        .busy(busy), .done(done), .err(err), .instr_count(instr_count)
    );

    // ROM and datapath stand-in: both follow pc, so ovf is held for the whole instruction.
    always @(negedge clk) begin
        instr = rom[pc];
        ovf   = ovfMap[pc];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic event_t makeEvent(input int kind, input int p, input int a,
                                         input logic [3:0] x, input logic [7:0] opc);
        event_t e;
        e.kind    = kind;
        e.pc      = 4'(p);
        e.addr    = 4'(a);
        e.x       = x;
        e.op      = opc;
        e.err     = 1'b0;
        e.count   = 8'd0;
        e.latency = 0;
        return e;
    endfunction

    // Instruction-level model: walks the ROM and accumulates cycle cost per instruction.
    task automatic buildExpected();
        event_t      e;
        int          p = 0;
        int          cycles = 0;
        int          count = 0;
        logic        errExp = 1'b0;
        logic [11:0] w;
        bit          running = 1'b1;
        bit          retired;
        while (running) begin
            w = rom[p];
            retired = 1'b0;
            case (w[10:8])
                3'b100: begin
                    cycles += 2;
                    running = 1'b0;
                end
                3'b101, 3'b110: begin
                    cycles += 2;
                    retired = 1'b1;
                end
                3'b111: begin
                    cycles += 2 + DEPTH;
                    for (int a = 0; a < DEPTH; a++)
                        expQ.push_back(makeEvent(KIND_DUMP, p, a, 4'h0, 8'h07));
                    retired = 1'b1;
                end
                default: begin
                    cycles += 2;
                    expQ.push_back(makeEvent(KIND_WRITE, p, int'(w[7:4]), w[3:0], {5'b0, w[10:8]}));
                    if (ovfMap[p]) begin
                        cycles += 1;
                        expQ.push_back(makeEvent(KIND_OVF, p, 0, 4'h0, 8'h00));
                    end
                    retired = 1'b1;
                end
            endcase
            if (retired) begin
                count = (count == 255) ? 255 : count + 1;
                if (p == 15) begin
                    errExp  = 1'b1;
                    running = 1'b0;
                end else begin
                    p++;
                end
            end
        end
        e = makeEvent(KIND_DONE, p, 0, 4'h0, 8'h00);
        e.err     = errExp;
        e.count   = 8'(count);
        // First busy cycle is seen one negedge after the start edge; done follows the last busy cycle.
        e.latency = cycles + 1;
        expQ.push_back(e);
    endtask

    // Monitor: pops one expected beat per write/dump cycle and one record when done rises.
    always @(negedge clk) begin
        event_t e;
        int     k;
        cyc++;
        if (rst_n) begin
            if (mem_we || dump_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedBeat", {30'b0, mem_we, dump_valid}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    k = dump_valid ? KIND_DUMP : (ovf_phase ? KIND_OVF : KIND_WRITE);
                    checkOutput("beatKind", k, e.kind);
                    checkOutput("beatPc", pc, e.pc);
                    checkOutput("beatBusy", busy, 1);
                    if (e.kind == KIND_WRITE) begin
                        checkOutput("writeOp", op, e.op);
                        checkOutput("writeAddr", addr_out, e.addr);
                        checkOutput("writeX", x_out, e.x);
                    end else if (e.kind == KIND_DUMP) begin
                        checkOutput("dumpAddr", dump_addr, e.addr);
                        checkOutput("dumpOp", op, 8'h07);
                        checkOutput("dumpNoWrite", mem_we, 0);
                    end else begin
                        checkOutput("ovfWrite", mem_we, 1);
                    end
                end
            end
            if (done && !prevDone) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", done, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("doneKind", KIND_DONE, e.kind);
                    checkOutput("donePc", pc, e.pc);
                    checkOutput("doneErr", err, e.err);
                    checkOutput("doneCount", instr_count, e.count);
                    checkOutput("doneLatency", cyc - startCyc, e.latency);
                    checkOutput("doneIdleOutputs", {busy, mem_we, ovf_phase, dump_valid, op}, 0);
                end
                doneCount++;
            end
        end
        prevDone = done;
    end

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_data"}, {pc, op, x_out, addr_out, dump_addr}, 0);
        checkOutput({name, "_count"}, instr_count, 0);
        checkOutput({name, "_flags"}, {mem_we, ovf_phase, dump_valid, busy, done, err}, 0);
    endtask

    task automatic startProgram();
        buildExpected();
        doneBase = doneCount;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        startCyc = cyc;
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("startPc", pc, 0);
        checkOutput("startCount", instr_count, 0);
        checkOutput("startErr", err, 0);
        checkOutput("startDone", done, 0);
        checkOutput("startBusy", busy, 1);
    endtask

    task automatic waitDone(input string name);
        int i = 0;
        while (doneCount == doneBase && i < 1000) begin
            @(negedge clk);
            i++;
        end
        checkOutput({name, "_finished"}, doneCount > doneBase, 1);
        checkOutput({name, "_queueEmpty"}, expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic applyStimulus(input string name, input bit busyPulse);
        startProgram();
        if (busyPulse) begin
            repeat ($urandom_range(1, 8)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        waitDone(name);
    endtask

    task automatic resetMid(input string name, input bit inDump);
        int i = 0;
        startProgram();
        while (i < 200 && !(inDump ? (dump_valid && dump_addr == 4'd4) : ovf_phase)) begin
            @(negedge clk);
            i++;
        end
        checkOutput({name, "_reached"}, i < 200, 1);
        #2 rst_n = 1'b0;
        #1 checkResetOutputs(name);
        expQ.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clearRom();
        for (int i = 0; i < 16; i++) begin
            rom[i]    = 12'h400;
            ovfMap[i] = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ovf   = 1'b0;
        instr = 12'h000;
        clearRom();
        #12;
        checkResetOutputs("powerOnReset");
        @(negedge clk);
        rst_n = 1'b1;

        rom[0] = 12'h035;
        applyStimulus("addThenHalt", 1'b0);

        rom[0] = 12'h1A3;
        ovfMap[0] = 1'b1;
        applyStimulus("ovfCorrection", 1'b0);

        rom[0] = 12'h700;
        applyStimulus("dumpThenHalt", 1'b0);

        for (int i = 0; i < 16; i++) rom[i] = 12'h500;
        applyStimulus("runOffEnd", 1'b0);

        clearRom();
        rom[0] = 12'h700;
        resetMid("resetInDump", 1'b1);
        applyStimulus("rerunAfterDumpReset", 1'b0);

        rom[0] = 12'h0F1;
        ovfMap[0] = 1'b1;
        resetMid("resetInOvf", 1'b0);
        applyStimulus("rerunAfterOvfReset", 1'b0);

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < 16; i++) begin
                rom[i]    = 12'($urandom_range(0, 4095));
                ovfMap[i] = 1'($urandom_range(0, 1));
            end
            applyStimulus("randomProgram", n[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
